// File: rtl/reciprocal_nr_unit.sv
// Iterative reciprocal: normalises x, then runs Newton-Raphson steps r <- r*(2 - x*r)
// on a single bit-serial shift-add multiplier (N cycles per multiply).
module reciprocal_nr_unit #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [N-1:0]  x,
  input  logic [3:0]    niter,
  output logic          busy,
  output logic          done,
  output logic          dz,
  output logic [N-1:0]  r_out,
  output logic [SW-1:0] shift
);

  localparam int BW = $clog2(N);
  localparam logic [N-1:0] ONE = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_MUL1, S_MUL2, S_DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_x, r_xn, r_r, r_mcand;
  logic [3:0]     r_iter;
  logic [SW-1:0]  r_sh;
  logic [BW-1:0]  r_bit;
  logic [2*N-1:0] r_prod;

  logic [SW-1:0]  w_lzc;
  logic [N-1:0]   w_xn, w_e, w_r_upd;
  logic [N:0]     w_sum;
  logic [2*N-1:0] w_prod_nxt;
  logic [3:0]     w_iter_dec;
  logic           w_mul_last;

  always_comb begin
    w_lzc = '0;
    for (int i = 0; i < N; i++)
      if (r_x[i]) w_lzc = SW'(N - 1 - i);
  end

  assign w_xn = r_x << w_lzc;

  // One shift-add step: low half holds the remaining multiplier bits, high half accumulates.
  assign w_sum      = {1'b0, r_prod[2*N-1:N]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nxt = {w_sum, r_prod[N-1:1]};
  assign w_mul_last = (r_bit == BW'(N - 1));
  assign w_e        = -w_prod_nxt[2*N-1:N];
  assign w_r_upd    = w_prod_nxt[2*N-1] ? '1 : w_prod_nxt[2*N-2:N-1];
  assign w_iter_dec = r_iter - 4'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_NORM;
      S_NORM: begin
        busy        = 1'b1;
        w_state_nxt = (r_x == '0 || r_iter == '0) ? S_DONE : S_MUL1;
      end
      S_MUL1: begin
        busy = 1'b1;
        if (w_mul_last) w_state_nxt = S_MUL2;
      end
      S_MUL2: begin
        busy = 1'b1;
        if (w_mul_last) w_state_nxt = (w_iter_dec != '0) ? S_MUL1 : S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_x     <= '0;
      r_xn    <= '0;
      r_r     <= '0;
      r_mcand <= '0;
      r_iter  <= '0;
      r_sh    <= '0;
      r_bit   <= '0;
      r_prod  <= '0;
      dz      <= 1'b0;
      r_out   <= '0;
      shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x    <= x;
            r_iter <= niter;
          end
        end
        S_NORM: begin
          r_xn    <= w_xn;
          r_sh    <= w_lzc;
          r_r     <= ONE;
          r_bit   <= '0;
          r_prod  <= {{N{1'b0}}, ONE};
          r_mcand <= w_xn;
          if (r_x == '0) begin
            dz    <= 1'b1;
            r_out <= '1;
            shift <= '0;
          end else if (r_iter == '0) begin
            dz    <= 1'b0;
            r_out <= ONE;
            shift <= w_lzc;
          end
        end
        S_MUL1: begin
          if (w_mul_last) begin
            // p = xn*r complete; reload multiplier with e = 2 - t, multiplicand with r
            r_bit   <= '0;
            r_prod  <= {{N{1'b0}}, w_e};
            r_mcand <= r_r;
          end else begin
            r_bit  <= r_bit + BW'(1);
            r_prod <= w_prod_nxt;
          end
        end
        S_MUL2: begin
          if (w_mul_last) begin
            r_bit   <= '0;
            r_r     <= w_r_upd;
            r_iter  <= w_iter_dec;
            r_prod  <= {{N{1'b0}}, w_r_upd};
            r_mcand <= r_xn;
            if (w_iter_dec == '0) begin
              dz    <= 1'b0;
              r_out <= w_r_upd;
              shift <= r_sh;
            end
          end else begin
            r_bit  <= r_bit + BW'(1);
            r_prod <= w_prod_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reciprocal_nr_unit.sv
// Directed + random bench for reciprocal_nr_unit (N=8) against an arithmetic reference.
module tb_reciprocal_nr_unit;

  localparam int N = 8;

  logic         clock, reset_n, start;
  logic [N-1:0] x;
  logic [3:0]   niter;
  logic         busy, done, dz;
  logic [N-1:0] r_out;
  logic [2:0]   shift;

  int errors = 0;
  int checks = 0;

  reciprocal_nr_unit #(.N(N)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .x(x), .niter(niter),
    .busy(busy), .done(done), .dz(dz), .r_out(r_out), .shift(shift)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reciprocal by the Newton-Raphson rules with plain integers.
  function automatic void model(input int xv, input int nv, output int er, output int esh,
                                output int edz, output int eedg);
    longint xn, r, t, e, q;
    if (xv == 0) begin
      er = (1 << N) - 1; esh = 0; edz = 1; eedg = 1;
      return;
    end
    xn = xv; esh = 0;
    while (xn < (1 << (N-1))) begin xn = xn * 2; esh++; end
    r = 1 << (N-1);
    for (int k = 0; k < nv; k++) begin
      t = (xn * r) >> N;
      e = ((1 << N) - t) % (1 << N);
      q = r * e;
      if (q >= (64'sd1 << (2*N-1))) r = (1 << N) - 1;
      else                          r = q >> (N-1);
    end
    er = int'(r); edz = 0;
    eedg = (nv == 0) ? 1 : 1 + 2*N*nv;
  endfunction

  // Called just after a clock edge with the DUT idle; returns one cycle after done.
  task automatic run(input logic [7:0] xv, input logic [3:0] nv, input int poke, input string tag);
    int er, esh, edz, eedg, cnt;
    bit seen;
    model(int'(xv), int'(nv), er, esh, edz, eedg);
    start = 1'b1; x = xv; niter = nv;
    @(posedge clock); #1;
    start = 1'b0; x = ~xv;
    cnt = 0; seen = 0;
    while (!seen && cnt < 300) begin
      if (cnt == poke) begin start = 1'b1; x = 8'h01; niter = 4'd1; end
      @(posedge clock); #1;
      start = 1'b0;
      cnt++;
      seen = done;
    end
    chk({tag, ":done_seen"}, seen, 1);
    chk({tag, ":latency"}, cnt + 1, eedg + 1);
    chk({tag, ":r_out"}, r_out, er);
    chk({tag, ":shift"}, shift, esh);
    chk({tag, ":dz"}, dz, edz);
    chk({tag, ":busy_with_done"}, busy, 0);
    @(posedge clock); #1;
    chk({tag, ":done_pulse"}, done, 0);
  endtask

  initial begin
    int hits;
    logic [7:0] xv;
    logic [3:0] nv;
    reset_n = 1'b0; start = 1'b0; x = '0; niter = '0;
    #3;
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:dz", dz, 0);
    chk("rst:r_out", r_out, 0);
    chk("rst:shift", shift, 0);
    #10 reset_n = 1'b1;

    run(8'h80, 4'd4, -1, "x80");
    chk("x80:const_r", r_out, 8'hFF);
    run(8'h03, 4'd4, -1, "x03");
    chk("x03:const_r", r_out, 8'hAB);
    chk("x03:const_sh", shift, 6);
    run(8'hFF, 4'd3, -1, "xFF");
    chk("xFF:const_r", r_out, 8'h81);
    run(8'h00, 4'd4, -1, "x00");
    chk("x00:const_dz", dz, 1);
    run(8'h80, 4'd4, -1, "x80_clr");
    chk("x80_clr:dz", dz, 0);

    // divide-by-zero, then a start held through the DONE cycle
    start = 1'b1; x = 8'h00; niter = 4'd0;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    chk("dz0:done", done, 1);
    chk("dz0:dz", dz, 1);
    start = 1'b1; x = 8'h40; niter = 4'd0;
    @(posedge clock); #1;
    chk("start_in_done:busy", busy, 0);
    chk("start_in_done:done", done, 0);
    @(posedge clock); #1;
    chk("start_after_done:busy", busy, 1);
    start = 1'b0;
    @(posedge clock); #1;
    chk("x40:done", done, 1);
    chk("x40:r_out", r_out, 8'h80);
    chk("x40:shift", shift, 1);
    chk("x40:dz", dz, 0);
    @(posedge clock); #1;

    run(8'h80, 4'd4, 9, "poke");

    // reset in the middle of a computation
    start = 1'b1; x = 8'h03; niter = 4'd4;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clock); #1; end
    chk("mid:busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort:busy", busy, 0);
    chk("abort:done", done, 0);
    chk("abort:dz", dz, 0);
    chk("abort:r_out", r_out, 0);
    chk("abort:shift", shift, 0);
    hits = 0;
    repeat (3) begin @(posedge clock); #1; if (done) hits++; end
    reset_n = 1'b1;
    repeat (70) begin @(posedge clock); #1; if (done) hits++; end
    chk("abort:no_done", hits, 0);
    run(8'h80, 4'd4, -1, "after_rst");

    for (int k = 0; k < 10; k++) begin
      xv = 8'($urandom_range(0, 255));
      nv = 4'($urandom_range(0, 5));
      run(xv, nv, -1, "rand");
    end
    run(8'h01, 4'd15, -1, "x01_n15");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reciprocal_nr_unit.md
RECIPROCAL_NR_UNIT -- requirements
Module: reciprocal_nr_unit

Interface
REQ-001 Parameter: N, default 8, operand/result width; legal range 4..16.
REQ-002 Parameter: SW, default $clog2(N), width of shift output (derived, not overridden).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; accepted only in IDLE.
REQ-006 x  input  N  unsigned operand, sampled on accepted start.
REQ-007 niter  input  4  Newton-Raphson iteration count 0..15, sampled on accepted start.
REQ-008 busy  output  1  high while in NORM, MUL1 or MUL2.
REQ-009 done  output  1  one-cycle pulse; results valid from this cycle.
REQ-010 dz  output  1  divide-by-zero flag, valid with done.
REQ-011 r_out  output  N  reciprocal mantissa, Q1.(N-1).
REQ-012 shift  output  SW  normalisation shift; 1/x ~= r_out * 2^(shift-(2N-1)).

Function
REQ-013 FSM states: IDLE, NORM, MUL1, MUL2, DONE. Only IDLE accepts start; start elsewhere is ignored.
REQ-014 IDLE + start=1 -> NORM next cycle; x and niter latched.
REQ-015 NORM (1 cycle): shift = leading-zero count of x; xn = x << shift, so xn[N-1]=1 (xn read as Q0.N in [0.5,1)); r = 2^(N-1) (1.0).
REQ-016 NORM exit: x==0 -> DONE with dz=1, r_out=all ones, shift=0; niter==0 -> DONE with r_out=2^(N-1); else -> MUL1 with iteration counter = niter.
REQ-017 MUL1 (exactly N cycles, internal shift-add, one multiplier bit per cycle): p = xn*r (2N bits); t = p[2N-1:N]; e = (~t + 1) mod 2^N (2.0 - t in Q1.(N-1)).
REQ-018 MUL2 (exactly N cycles, same multiplier): q = r*e (2N bits); r <= all ones if q[2N-1]=1 (saturate), else q[2N-2:N-1] (truncate).
REQ-019 After MUL2: counter decrements; nonzero -> MUL1, zero -> DONE.
REQ-020 DONE (1 cycle): done=1, busy=0, r_out/shift/dz updated; next state IDLE.
REQ-021 Latency: start accepted at edge 0 -> done high in cycle 2 + 2*N*niter (2 for x==0 or niter==0).
REQ-022 r_out, shift, dz hold their values from DONE until the next DONE; dz cleared on a non-zero result.
REQ-023 One shared multiplier only; no second multiply in flight.
REQ-024 busy and done never both high; start in DONE cycle ignored (accepted in following IDLE cycle).

Reset
REQ-025 reset_n low forces, immediately and without clock: state=IDLE, busy=0, done=0, dz=0, r_out=0, shift=0, internal registers/counters 0.
REQ-026 Reset mid-operation aborts the computation; no done is produced for it.
REQ-027 After reset_n rises, first rising edge with start=1 is accepted normally.

Verification (N=8)
REQ-028 x=0x80, niter=4 -> done at cycle 66, r_out=0xFF (last MUL2 saturates), shift=0, dz=0.
REQ-029 x=0x03, niter=4 -> done at cycle 66, r_out=0xAB, shift=6; x=0xFF, niter=3 -> done at cycle 50, r_out=0x81, shift=0.
REQ-030 x=0x00, niter=4 -> done at cycle 2, dz=1, r_out=0xFF, shift=0; next x=0x80 result clears dz.
REQ-031 x=0x40, niter=0 -> done at cycle 2, r_out=0x80, shift=1, dz=0.
REQ-032 Start x=0x80, niter=4; pulse start with x=0x01 at cycle 10 -> ignored, result as REQ-028; reset_n low at cycle 20 -> all outputs 0 at once, no done; restart after release completes in 66 cycles.
